// File: rtl/wfg_drive_spi_arb_if.sv
// Bundle of the requester-side, driver-side and status signals of wfg_drive_spi_arb.
// slave = the arbiter's view, master = the surrounding logic's view.
interface wfg_drive_spi_arb_if #(
    parameter int NUM_REQ         = 4,
    parameter int AXIS_DATA_WIDTH = 32
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                               ctrl_en_q_i;
    logic [NUM_REQ-1:0]                 cfg_mask_q_i;
    logic [NUM_REQ-1:0]                 s_axis_tvalid_i;
    logic [NUM_REQ-1:0]                 s_axis_tlast_i;
    logic [NUM_REQ*AXIS_DATA_WIDTH-1:0] s_axis_tdata_i;
    logic [NUM_REQ-1:0]                 s_axis_tready_o;
    logic                               m_axis_tvalid_o;
    logic                               m_axis_tlast_o;
    logic [AXIS_DATA_WIDTH-1:0]         m_axis_tdata_o;
    logic                               m_axis_tready_i;
    logic [ID_W-1:0]                    gnt_id_o;
    logic [NUM_REQ-1:0]                 spi_sel_o;
    logic                               busy_o;

    modport slave (
        input  ctrl_en_q_i, cfg_mask_q_i,
        input  s_axis_tvalid_i, s_axis_tlast_i, s_axis_tdata_i,
        output s_axis_tready_o,
        output m_axis_tvalid_o, m_axis_tlast_o, m_axis_tdata_o,
        input  m_axis_tready_i,
        output gnt_id_o, spi_sel_o, busy_o
    );

    modport master (
        output ctrl_en_q_i, cfg_mask_q_i,
        output s_axis_tvalid_i, s_axis_tlast_i, s_axis_tdata_i,
        input  s_axis_tready_o,
        input  m_axis_tvalid_o, m_axis_tlast_o, m_axis_tdata_o,
        output m_axis_tready_i,
        input  gnt_id_o, spi_sel_o, busy_o
    );
endinterface

// File: rtl/wfg_drive_spi_arb.sv
// Round-robin arbiter sharing one wfg_drive_spi between NUM_REQ AXI-stream requesters.
// Define WFG_DRIVE_SPI_ARB_PKT_LOCK_EN to hold a grant until the word carrying tlast.
module wfg_drive_spi_arb #(
    parameter int NUM_REQ         = 4,
    parameter int AXIS_DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    wfg_drive_spi_arb_if.slave  bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_GRANT = 2'd2
    } state_e;

    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    gnt_q;
    logic [NUM_REQ-1:0] sel_q;
    logic               busy_q;

    logic [NUM_REQ-1:0] req;
    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    ptr_d;
    logic               hs;
    logic               release_gnt;

    assign req = bus.s_axis_tvalid_i & bus.cfg_mask_q_i & {NUM_REQ{bus.ctrl_en_q_i}};

    // First requesting index at or above the pointer, wrapping past NUM_REQ-1.
    always_comb begin
        int unsigned idx;
        // NOTE: every combinationally driven variable gets a default first so no path infers a latch.
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    assign ptr_d = (gnt_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
    assign hs    = bus.s_axis_tvalid_i[gnt_q] & bus.m_axis_tready_i;

`ifdef WFG_DRIVE_SPI_ARB_PKT_LOCK_EN
    assign release_gnt = hs & bus.s_axis_tlast_i[gnt_q];
`else
    assign release_gnt = hs;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q <= ST_ARB;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (win_found) begin
                        gnt_q   <= win_idx;
                        sel_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                        state_q <= ST_GRANT;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // The grant is never revoked; only a completed transfer ends it.
                    if (release_gnt) begin
                        ptr_q   <= ptr_d;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.m_axis_tvalid_o = 1'b0;
        bus.m_axis_tlast_o  = 1'b0;
        bus.m_axis_tdata_o  = '0;
        bus.s_axis_tready_o = '0;
        if (state_q == ST_GRANT) begin
            bus.m_axis_tvalid_o        = bus.s_axis_tvalid_i[gnt_q];
            bus.m_axis_tlast_o         = bus.s_axis_tlast_i[gnt_q];
            bus.m_axis_tdata_o         = bus.s_axis_tdata_i[int'(gnt_q)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
            bus.s_axis_tready_o[gnt_q] = bus.m_axis_tready_i;
        end
    end

    assign bus.gnt_id_o  = gnt_q;
    assign bus.spi_sel_o = sel_q;
    assign bus.busy_o    = busy_q;

endmodule

// File: tb/tb_wfg_drive_spi_arb.sv
// Randomized self-checking bench for wfg_drive_spi_arb against a transaction-level round-robin model.
// Honours WFG_DRIVE_SPI_ARB_PKT_LOCK_EN in the packet scenario.
module tb_wfg_drive_spi_arb;
    localparam int N = 4;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wfg_drive_spi_arb_if #(.NUM_REQ(N), .AXIS_DATA_WIDTH(W)) bus ();

    wfg_drive_spi_arb #(.NUM_REQ(N), .AXIS_DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int model_ptr;
    logic [W-1:0] word [N];

    // Reference: first requester at or after ptr (with wrap) that is valid, enabled and unmasked.
    function automatic int model_winner(int ptr, logic [N-1:0] v, logic [N-1:0] m, logic en);
        if (!en) return -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (v[k] && m[k]) return k;
        end
        return -1;
    endfunction

    task automatic set_word(input int k, input logic [W-1:0] d);
        word[k] = d;
        bus.s_axis_tdata_i[k*W +: W] = d;
    endtask

    task automatic apply_reset();
        bus.ctrl_en_q_i     = 1'b0;
        bus.cfg_mask_q_i    = '0;
        bus.s_axis_tvalid_i = '0;
        bus.s_axis_tlast_i  = '0;
        bus.m_axis_tready_i = 1'b0;
        for (int k = 0; k < N; k++) set_word(k, $urandom);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
    endtask

    // Waits for a grant, holds it for 'delay' cycles, then pulses the driver ready for one cycle.
    task automatic serve_grant(input int delay, output int id, output logic [N-1:0] sel,
                               output logic [W-1:0] data, output logic last, output logic held,
                               output logic [N-1:0] rdy_pulse, output logic [N-1:0] rdy_after,
                               output bit timeout);
        id = -1; sel = '0; data = '0; last = 1'b0; held = 1'b0;
        rdy_pulse = '0; rdy_after = '0; timeout = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (bus.m_axis_tvalid_o === 1'b1) begin
                timeout = 1'b0;
                break;
            end
        end
        if (timeout) return;
        id   = int'(bus.gnt_id_o);
        sel  = bus.spi_sel_o;
        data = bus.m_axis_tdata_o;
        last = bus.m_axis_tlast_o;
        held = 1'b1;
        repeat (delay) begin
            @(negedge clk); #1;
            if (bus.m_axis_tvalid_o !== 1'b1) held = 1'b0;
        end
        @(negedge clk);
        bus.m_axis_tready_i = 1'b1;
        #1 rdy_pulse = bus.s_axis_tready_o;
        @(negedge clk);
        bus.m_axis_tready_i = 1'b0;
        #1 rdy_after = bus.s_axis_tready_o;
    endtask

    task automatic test_reset();
        bus.ctrl_en_q_i     = 1'b1;
        bus.cfg_mask_q_i    = '1;
        bus.s_axis_tvalid_i = '1;
        bus.s_axis_tlast_i  = '1;
        bus.s_axis_tdata_i  = '1;
        bus.m_axis_tready_i = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.m_axis_tvalid_o, bus.m_axis_tlast_o, bus.busy_o} !== 3'b000) begin
            n_err++; $display("FAIL reset_ctrl: got %b expected 000", {bus.m_axis_tvalid_o, bus.m_axis_tlast_o, bus.busy_o});
        end
        n_cmp++;
        if (bus.m_axis_tdata_o !== '0) begin
            n_err++; $display("FAIL reset_tdata: got %h expected 0", bus.m_axis_tdata_o);
        end
        n_cmp++;
        if ({bus.s_axis_tready_o, bus.spi_sel_o} !== '0) begin
            n_err++; $display("FAIL reset_ready_sel: got %b expected 0", {bus.s_axis_tready_o, bus.spi_sel_o});
        end
        n_cmp++;
        if (bus.gnt_id_o !== '0) begin
            n_err++; $display("FAIL reset_gnt_id: got %0d expected 0", bus.gnt_id_o);
        end
    endtask

    task automatic test_single_requester();
        int id; logic [N-1:0] sel, rp, ra; logic [W-1:0] d; logic l, held; bit to; int exp;
        apply_reset();
        bus.ctrl_en_q_i  = 1'b1;
        bus.cfg_mask_q_i = 4'hF;
        set_word(2, 32'hA5A5_0001);
        bus.s_axis_tvalid_i = 4'b0100;
        exp = model_winner(model_ptr, bus.s_axis_tvalid_i, bus.cfg_mask_q_i, 1'b1);
        serve_grant(4, id, sel, d, l, held, rp, ra, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL single_timeout: no grant within bound"); end
        n_cmp++;
        if (id !== exp) begin n_err++; $display("FAIL single_gnt_id: got %0d expected %0d", id, exp); end
        n_cmp++;
        if (d !== 32'hA5A5_0001) begin n_err++; $display("FAIL single_tdata: got %h expected a5a50001", d); end
        n_cmp++;
        if (sel !== 4'b0100) begin n_err++; $display("FAIL single_sel: got %b expected 0100", sel); end
        n_cmp++;
        if (held !== 1'b1) begin n_err++; $display("FAIL single_hold: tvalid dropped before ack"); end
        n_cmp++;
        if (rp !== 4'b0100 || ra !== 4'b0000) begin
            n_err++; $display("FAIL single_ready: got %b then %b expected 0100 then 0000", rp, ra);
        end
        model_ptr = (exp + 1) % N;
        bus.s_axis_tvalid_i = 4'b1111;
        exp = model_winner(model_ptr, bus.s_axis_tvalid_i, bus.cfg_mask_q_i, 1'b1);
        serve_grant(0, id, sel, d, l, held, rp, ra, to);
        n_cmp++;
        if (to || id !== exp) begin n_err++; $display("FAIL single_next_ptr: got %0d expected %0d", id, exp); end
        model_ptr = (exp + 1) % N;
    endtask

    task automatic run_rr(input string name, input logic [N-1:0] mask, input int n_gnt);
        int id; logic [N-1:0] sel, rp, ra; logic [W-1:0] d; logic l, held; bit to; int exp;
        apply_reset();
        bus.ctrl_en_q_i     = 1'b1;
        bus.cfg_mask_q_i    = mask;
        bus.s_axis_tvalid_i = '1;
        for (int g = 0; g < n_gnt; g++) begin
            exp = model_winner(model_ptr, bus.s_axis_tvalid_i, mask, 1'b1);
            serve_grant($urandom_range(0, 3), id, sel, d, l, held, rp, ra, to);
            n_cmp++;
            if (to || id !== exp) begin n_err++; $display("FAIL %s_order[%0d]: got %0d expected %0d", name, g, id, exp); end
            n_cmp++;
            if (!$onehot(sel) || sel !== (N'(1) << exp)) begin
                n_err++; $display("FAIL %s_sel[%0d]: got %b expected one-hot of %0d", name, g, sel, exp);
            end
            n_cmp++;
            if (exp >= 0 && d !== word[exp]) begin n_err++; $display("FAIL %s_data[%0d]: got %h expected %h", name, g, d, word[exp]); end
            n_cmp++;
            if ((rp & ~mask) !== '0 || rp !== (N'(1) << exp)) begin
                n_err++; $display("FAIL %s_ready[%0d]: got %b expected one-hot of %0d", name, g, rp, exp);
            end
            if (exp >= 0) begin
                model_ptr = (exp + 1) % N;
                set_word(exp, $urandom);
            end
        end
    endtask

    task automatic test_round_robin();
        run_rr("rr", 4'b1111, 6);
    endtask

    task automatic test_mask();
        run_rr("mask", 4'b1010, 4);
    endtask

    task automatic test_enable_drop();
        bit to; logic held; logic [W-1:0] d;
        apply_reset();
        bus.ctrl_en_q_i     = 1'b1;
        bus.cfg_mask_q_i    = 4'hF;
        bus.s_axis_tvalid_i = 4'b0010;
        d  = word[1];
        to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (bus.m_axis_tvalid_o === 1'b1) begin to = 1'b0; break; end
        end
        n_cmp++;
        if (to) begin n_err++; $display("FAIL en_drop_timeout: no grant within bound"); end
        bus.ctrl_en_q_i = 1'b0;
        held = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            if (bus.m_axis_tvalid_o !== 1'b1 || bus.m_axis_tdata_o !== d) held = 1'b0;
        end
        n_cmp++;
        if (!held) begin n_err++; $display("FAIL en_drop_hold: grant lost after enable dropped"); end
        @(negedge clk);
        bus.m_axis_tready_i = 1'b1;
        #1;
        n_cmp++;
        if (bus.s_axis_tready_o !== 4'b0010) begin n_err++; $display("FAIL en_drop_ready: got %b expected 0010", bus.s_axis_tready_o); end
        @(negedge clk);
        bus.m_axis_tready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (bus.busy_o !== 1'b0 || bus.m_axis_tvalid_o !== 1'b0 || bus.spi_sel_o !== 4'b0010) begin
                n_err++; $display("FAIL en_drop_idle[%0d]: busy %b tvalid %b sel %b expected 0 0 0010",
                                  i, bus.busy_o, bus.m_axis_tvalid_o, bus.spi_sel_o);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        int id; logic [N-1:0] sel, rp, ra, v; logic [W-1:0] d; logic l, held; bit to; int exp;
        apply_reset();
        bus.ctrl_en_q_i     = 1'b1;
        bus.cfg_mask_q_i    = 4'hF;
        bus.s_axis_tvalid_i = N'($urandom_range(1, 15));
        to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (bus.m_axis_tvalid_o === 1'b1) begin to = 1'b0; break; end
        end
        n_cmp++;
        if (to) begin n_err++; $display("FAIL midrst_timeout: no grant within bound"); end
        bus.m_axis_tready_i = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.m_axis_tvalid_o, bus.m_axis_tlast_o, bus.busy_o, bus.s_axis_tready_o, bus.spi_sel_o} !== '0
            || bus.m_axis_tdata_o !== '0 || bus.gnt_id_o !== '0) begin
            n_err++; $display("FAIL midrst_outputs: valid %b busy %b ready %b sel %b gnt %0d data %h expected all 0",
                              bus.m_axis_tvalid_o, bus.busy_o, bus.s_axis_tready_o, bus.spi_sel_o, bus.gnt_id_o, bus.m_axis_tdata_o);
        end
        @(negedge clk);
        bus.m_axis_tready_i = 1'b0;
        v = N'($urandom_range(1, 15));
        bus.s_axis_tvalid_i = v;
        rst_n = 1'b1;
        model_ptr = 0;
        exp = model_winner(model_ptr, v, 4'hF, 1'b1);
        serve_grant(1, id, sel, d, l, held, rp, ra, to);
        n_cmp++;
        if (to || id !== exp || d !== word[exp]) begin
            n_err++; $display("FAIL midrst_first_grant: got %0d/%h expected %0d/%h", id, d, exp, word[exp]);
        end
    endtask

    task automatic test_packet();
        int id; logic [N-1:0] sel, rp, ra; logic [W-1:0] d; logic l, held; bit to;
        int exp, idx0, lock_g; bit locked, lock_mode;
        logic [W-1:0] pkt [3];
`ifdef WFG_DRIVE_SPI_ARB_PKT_LOCK_EN
        lock_mode = 1'b1;
`else
        lock_mode = 1'b0;
`endif
        apply_reset();
        for (int i = 0; i < 3; i++) pkt[i] = $urandom;
        bus.ctrl_en_q_i    = 1'b1;
        bus.cfg_mask_q_i   = 4'hF;
        idx0 = 0;
        set_word(0, pkt[0]);
        bus.s_axis_tlast_i = 4'b0010;
        bus.s_axis_tvalid_i = 4'b0011;
        locked = 1'b0;
        lock_g = 0;
        for (int g = 0; g < 4; g++) begin
            exp = locked ? lock_g : model_winner(model_ptr, bus.s_axis_tvalid_i, 4'hF, 1'b1);
            serve_grant($urandom_range(0, 2), id, sel, d, l, held, rp, ra, to);
            n_cmp++;
            if (to || id !== exp || d !== word[exp]) begin
                n_err++; $display("FAIL pkt_word[%0d]: got %0d/%h expected %0d/%h", g, id, d, exp, word[exp]);
            end
            n_cmp++;
            if (l !== bus.s_axis_tlast_i[exp]) begin n_err++; $display("FAIL pkt_last[%0d]: got %b expected %b", g, l, bus.s_axis_tlast_i[exp]); end
            if (lock_mode && !bus.s_axis_tlast_i[exp]) begin
                locked = 1'b1; lock_g = exp;
            end else begin
                locked = 1'b0; model_ptr = (exp + 1) % N;
            end
            if (exp == 0) begin
                idx0++;
                if (idx0 == 3) bus.s_axis_tvalid_i[0] = 1'b0;
                else begin
                    set_word(0, pkt[idx0]);
                    bus.s_axis_tlast_i[0] = (idx0 == 2);
                end
            end else begin
                set_word(exp, $urandom);
            end
        end
        bus.s_axis_tvalid_i = '0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_requester();
        test_round_robin();
        test_mask();
        test_enable_drop();
        test_reset_mid_grant();
        test_packet();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wfg_drive_spi_arb.md
Name: wfg_drive_spi_arb

Overview:
Round-robin arbiter that shares one wfg_drive_spi instance between NUM_REQ AXI-stream requesters.
- Selects one requester, muxes its stream onto the single downstream AXIS port, and routes the SPI driver's one-cycle tready pulse back to that requester.
- Drives a registered one-hot slave-select vector so board logic can steer the shared chip select.
- Sits between the pattern/channel blocks and the SPI driver.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
AXIS_DATA_WIDTH, 32, stream data width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ctrl_en_q_i  input  1  arbiter enable
cfg_mask_q_i  input  NUM_REQ  per-requester enable mask, 1 = may be granted
s_axis_tvalid_i  input  NUM_REQ  requester valid
s_axis_tlast_i  input  NUM_REQ  requester last
s_axis_tdata_i  input  NUM_REQ*AXIS_DATA_WIDTH  requester data; requester k occupies slice [k*W +: W]
s_axis_tready_o  output  NUM_REQ  requester ready
m_axis_tvalid_o  output  1  to SPI driver valid
m_axis_tlast_o  output  1  to SPI driver last
m_axis_tdata_o  output  AXIS_DATA_WIDTH  to SPI driver data
m_axis_tready_i  input  1  from SPI driver ready (one-cycle pulse)
gnt_id_o  output  $clog2(NUM_REQ)  index of current/last granted requester
spi_sel_o  output  NUM_REQ  one-hot slave select of last granted requester
busy_o  output  1  1 while in ST_ARB or ST_GRANT

Behaviour:
Reset values:
- All outputs 0.
- Round-robin pointer = 0.
- State = ST_IDLE.

Request qualification: req[k] = s_axis_tvalid_i[k] & cfg_mask_q_i[k] & ctrl_en_q_i.

ST_IDLE:
- If any req → ST_ARB.
- Otherwise stay.
- All m_axis outputs and s_axis_tready_o are 0.

ST_ARB (exactly one cycle):
- Winner = first index with req set, searching from the pointer upward with wrap (pointer, pointer+1, ..., NUM_REQ-1, 0, ...).
- Registered on the cycle's clock edge, together with gnt_id_o and spi_sel_o (one-hot of winner).
- Next state ST_GRANT.
- If req dropped to all-zero in this cycle → ST_IDLE; gnt_id_o and spi_sel_o are unchanged.

ST_GRANT (combinational mux from granted index g):
- m_axis_tvalid_o = s_axis_tvalid_i[g]; m_axis_tdata_o and m_axis_tlast_o come from requester g.
- s_axis_tready_o[g] = m_axis_tready_i; all other ready bits are 0.
- Handshake = m_axis_tvalid_o & m_axis_tready_i.
- On handshake: pointer <= (g+1) mod NUM_REQ, then → ST_IDLE. Minimum two-cycle gap between grants, which is negligible against SPI frame time.
- No handshake: stay; the grant is never revoked.
- ctrl_en_q_i or cfg_mask_q_i changes do not affect an active grant; they take effect at the next ST_ARB.

spi_sel_o and gnt_id_o:
- Hold their values after the handshake until the next ST_ARB winner, so chip-select steering stays stable while the SPI driver shifts the frame.
- Never more than one bit of spi_sel_o is set.

Fairness: with all NUM_REQ requesting continuously, each is granted once per NUM_REQ grants.

Reset mid-operation: immediate return to the reset values above. Pending requester data is not acknowledged.

Optional Feature:
Macro: WFG_DRIVE_SPI_ARB_PKT_LOCK_EN.
- Defined: on a handshake with m_axis_tlast_o = 0, stay in ST_GRANT with the same g and leave the pointer unchanged. The grant is released (pointer advance, → ST_IDLE) only on a handshake with tlast = 1. A multi-word packet therefore goes to one slave without interleaving. Mask/enable changes still do not break the lock.
- Undefined: tlast is passed through only; arbitration occurs per word.

Test Plan:
1. Reset, ctrl_en=1, mask=4'hF, only requester 2 valid with data 32'hA5A5_0001. Driver pulses tready 5 cycles after ST_GRANT entry. Required: m_axis_tdata_o=32'hA5A5_0001; s_axis_tready_o=4'b0100 for exactly one cycle; spi_sel_o=4'b0100; gnt_id_o=2; pointer then 3.
2. All four valid continuously, driver acks every grant. Required: grant order 0,1,2,3,0,1; spi_sel_o is one-hot every cycle.
3. mask=4'b1010, all valid. Required: only 1,3,1,3 are granted; requesters 0 and 2 never see tready.
4. Requester 1 granted, ctrl_en dropped before the ack. Required: m_axis_tvalid_o stays 1 until the ack, then ST_IDLE; no new grant while en=0; spi_sel_o holds 4'b0010.
5. Assert rst_n low while in ST_GRANT. Required: all outputs 0 immediately; after release, first grant goes to the lowest requesting index from pointer 0.
6. With PKT_LOCK_EN: requester 0 sends 3 words (tlast on the 3rd) while requester 1 is also valid. Required: all three words come from requester 0 before requester 1 is granted. Without the macro: order 0,1,0,… .
